// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory reader feeding a 2-entry {pc, word} queue.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirect targets into HALT with fault raised.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

    state_t      state, state_nx;
    logic [31:0] fpc, fpc_nx;
    logic [31:0] drain_addr, drain_addr_nx;
    logic [31:0] q_addr [2];
    logic [31:0] q_data [2];
    logic        hd, hd_nx;
    logic        tail;
    logic [1:0]  count, count_nx;
    logic        fault_q, fault_nx;
    logic        push, pop, mis;
    logic [31:0] tgt;

    assign tgt = {pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_TRAP_EN
    assign mis = (pc[1:0] != 2'b00);
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];
    assign mis = 1'b0;
`endif

    assign inst_valid = (count != 2'd0);
    assign inst       = q_data[hd];
    assign inst_pc    = q_addr[hd];
    assign imem_req   = (state == REQ) || (state == DRAIN);
    // DRAIN must keep presenting the abandoned address while fpc already points at the new target.
    assign imem_addr  = (state == DRAIN) ? drain_addr : fpc;
    assign fault      = fault_q;
    assign pop        = inst_valid & inst_ready & ~redirect;
    assign tail       = hd ^ count[0];

    always_comb begin
        state_nx      = state;
        fpc_nx        = fpc;
        drain_addr_nx = drain_addr;
        fault_nx      = fault_q;
        push          = 1'b0;
        hd_nx         = hd ^ pop;
        count_nx      = count - {1'b0, pop};

        if (redirect) begin
            count_nx = '0;
            hd_nx    = hd;
            fpc_nx   = tgt;
            fault_nx = mis;
        end

        case (state)
            IDLE: begin
                if (redirect) begin
                    state_nx = mis ? HALT : REQ;
                end else if (count_nx < 2'd2) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        state_nx = mis ? HALT : REQ;
                    end else begin
                        state_nx      = DRAIN;
                        drain_addr_nx = fpc;
                    end
                end else if (imem_ack) begin
                    push     = 1'b1;
                    fpc_nx   = fpc + 32'd4;
                    count_nx = count_nx + 2'd1;
                    state_nx = (count_nx == 2'd2) ? IDLE : REQ;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_nx = fault_nx ? HALT : REQ;
                end
            end
            HALT: begin
                if (redirect && !mis) begin
                    state_nx = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            drain_addr <= RESET_PC;
            hd         <= 1'b0;
            count      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            fpc        <= fpc_nx;
            drain_addr <= drain_addr_nx;
            hd         <= hd_nx;
            count      <= count_nx;
            fault_q    <= fault_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= fpc;
            q_data[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;

`ifdef IFU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int wcnt;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: acknowledges after `lat` wait cycles, data is a fixed function of address.
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = word_of(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched instructions plus outstanding-request bookkeeping.
    logic [31:0] mq_a[$];
    logic [31:0] mq_d[$];
    logic [31:0] m_fpc = '0, m_raddr = '0;
    bit m_req = 0, m_disc = 0, m_halt = 0, m_fault = 0;

    task automatic model_step();
        bit mack, mis;
        if (rst) begin
            mq_a.delete(); mq_d.delete();
            m_fpc = '0; m_raddr = '0;
            m_req = 0; m_disc = 0; m_halt = 0; m_fault = 0;
            return;
        end
        mack = m_req && imem_ack;
        mis  = TRAP && (pc[1:0] != 2'b00);
        if (redirect) begin
            mq_a.delete(); mq_d.delete();
            m_fpc   = {pc[31:2], 2'b00};
            m_fault = mis;
            if (m_req && !mack) begin
                m_disc = 1;
            end else begin
                m_req = !mis; m_halt = mis; m_disc = 0; m_raddr = m_fpc;
            end
        end else begin
            if (mq_a.size() != 0 && inst_ready) begin
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
            end
            if (mack) begin
                if (m_disc) begin
                    m_disc = 0; m_halt = m_fault; m_req = !m_fault; m_raddr = m_fpc;
                end else begin
                    mq_a.push_back(m_raddr);
                    mq_d.push_back(word_of(m_raddr));
                    m_fpc   = m_fpc + 32'd4;
                    m_req   = (mq_a.size() < 2);
                    m_raddr = m_fpc;
                end
            end else if (!m_req && !m_halt && mq_a.size() < 2) begin
                m_req = 1; m_raddr = m_fpc;
            end
        end
    endtask

    task automatic compare();
        chk1("m_imem_req", imem_req, m_req);
        if (m_req) chk("m_imem_addr", imem_addr, m_raddr);
        chk1("m_inst_valid", inst_valid, mq_a.size() != 0);
        if (mq_a.size() != 0) begin
            chk("m_inst_pc", inst_pc, mq_a[0]);
            chk("m_inst", inst, mq_d[0]);
        end
        chk1("m_fault", fault, m_fault);
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        compare();
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int l, input logic rdy);
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; inst_ready = rdy; lat = l;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1011_0010;

        // Reset values
        cyc(2);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);

        // Zero-wait streaming
        inst_ready = 1'b1;
        rst = 1'b0;
        cyc(1);
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        cyc(1);
        chk1("stream_valid0", inst_valid, 1'b1);
        chk("stream_pc0", inst_pc, 32'h0);
        cyc(1);
        chk("stream_pc1", inst_pc, 32'h4);
        cyc(1);
        chk("stream_pc2", inst_pc, 32'h8);
        chk("stream_inst2", inst, 32'h8 ^ 32'h5A5A_C3C3);

        // Backpressure saturation
        do_reset(0, 1'b0);
        cyc(12);
        chk1("sat_req", imem_req, 1'b0);
        chk1("sat_valid", inst_valid, 1'b1);
        chk("sat_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        cyc(1);
        chk("rel_pc", inst_pc, 32'h4);
        chk1("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, 32'h8);

        // Redirect during a wait cycle
        do_reset(2, 1'b1);
        cyc(1);
        chk1("lat_req", imem_req, 1'b1);
        redirect = 1'b1; pc = 32'h100;
        cyc(1);
        redirect = 1'b0;
        chk("drain_addr", imem_addr, 32'h0);
        cyc(2);
        chk("drain_new_addr", imem_addr, 32'h100);
        chk1("drain_no_valid", inst_valid, 1'b0);
        for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
        chk1("drain_valid", inst_valid, 1'b1);
        chk("drain_first_pc", inst_pc, 32'h100);

        // Reset while a request is outstanding
        for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
        chk1("pre_abandon_req", imem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("abandon_req", imem_req, 1'b0);

        // Redirect coincident with ack and pop
        do_reset(0, 1'b1);
        cyc(4);
        chk1("coinc_pre_valid", inst_valid, 1'b1);
        redirect = 1'b1; pc = 32'h200;
        cyc(1);
        redirect = 1'b0;
        chk1("coinc_empty", inst_valid, 1'b0);
        chk("coinc_addr", imem_addr, 32'h200);
        cyc(1);
        chk("coinc_pc", inst_pc, 32'h200);

        // Address wrap
        redirect = 1'b1; pc = 32'hFFFF_FFFC;
        cyc(1);
        redirect = 1'b0;
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        chk("wrap_zero", imem_addr, 32'h0);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

        // Misaligned redirect
        redirect = 1'b1; pc = 32'h102;
        cyc(1);
        redirect = 1'b0;
        chk1("mis_fault", fault, TRAP);
        chk1("mis_req", imem_req, !TRAP);
`ifndef IFU_MISALIGN_TRAP_EN
        chk("mis_addr", imem_addr, 32'h100);
`endif
        cyc(3);
        chk1("mis_hold_fault", fault, TRAP);
        redirect = 1'b1; pc = 32'h104;
        cyc(1);
        redirect = 1'b0;
        chk1("align_fault", fault, 1'b0);
        chk1("align_req", imem_req, 1'b1);
        chk("align_addr", imem_addr, 32'h104);

        // Mixed backpressure with one-wait memory and a mid-stream redirect
        do_reset(1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            inst_ready = pat[i % 8];
            redirect   = (i == 20);
            pc         = 32'h40;
            @(negedge clk);
        end
        redirect = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
